// File: rtl/dl_ram_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dl_ram_writer_pkg
//  Description : Shared definitions for the download RAM writer: FSM state
//                encodings and default bus widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package dl_ram_writer_pkg;

    // Download / CPU byte address width and default FIFO depth exponent.
    localparam int AW_DEFAULT         = 25;
    localparam int DEPTH_LOG2_DEFAULT = 2;

    // Arbiter / replay FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DL_WR   = 2'd1,
        ST_CPU_ACC = 2'd2
    } state_t;

endpackage : dl_ram_writer_pkg
`default_nettype wire

// File: rtl/dl_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dl_fifo
//  Description : Small synchronous FIFO with first-word-fall-through read
//                port. A push into a full FIFO is still accepted when a pop
//                happens in the same cycle; otherwise it is dropped and
//                flagged on 'drop' for that cycle.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk    in   1      clock
//    reset  in   1      asynchronous active-high reset (empties the FIFO)
//    push   in   1      write request
//    wdata  in   WIDTH  write data
//    pop    in   1      read/advance request (ignored when empty)
//    rdata  out  WIDTH  head entry (valid when !empty)
//    full   out  1      all slots occupied
//    empty  out  1      no slots occupied
//    drop   out  1      push rejected this cycle (full, no pop)
// ============================================================================
module dl_fifo #(
    parameter int WIDTH      = 33,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // One extra pointer bit distinguishes full from empty.
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic                push_ok;
    logic                pop_ok;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                  (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
        pop_ok  = pop && !empty;
        // A simultaneous pop frees the slot the push is about to use.
        push_ok = push && (!full || pop_ok);
        drop    = push && full && !pop_ok;
        wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, pop_ok};
        rdata    = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define which slots are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata;
        end
    end

endmodule : dl_fifo
`default_nettype wire

// File: rtl/dl_ram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : dl_ram_writer
//  Description : Queues single-cycle byte writes from the download stage and
//                replays them to a single-port SDRAM controller over a
//                req/ack handshake, arbitrating with the CPU memory port.
//                Download writes win while downloading; otherwise a pending
//                CPU access goes first, alternating with queued writes.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk          in   1   system clock
//    reset        in   1   asynchronous active-high reset
//    dl_wr        in   1   one-cycle download write strobe
//    dl_addr      in   AW  download byte address
//    dl_data      in   8   download byte
//    downloading  in   1   download active: download queue has priority
//    cpu_req      in   1   CPU request level, held until cpu_ack
//    cpu_we       in   1   CPU write(1) / read(0)
//    cpu_addr     in   AW  CPU byte address
//    cpu_din      in   8   CPU write data
//    cpu_ack      out  1   one-cycle CPU completion pulse
//    cpu_dout     out  8   CPU read data, held until next read completes
//    ram_req      out  1   SDRAM request, held until ram_ack
//    ram_we       out  1   SDRAM write qualifier
//    ram_addr     out  AW  SDRAM byte address
//    ram_din      out  8   SDRAM write data
//    ram_ack      in   1   one-cycle SDRAM completion
//    ram_dout     in   8   SDRAM read data, valid with ram_ack
//    dl_busy      out  1   queued or in-flight download write
//    dl_overflow  out  1   sticky: a download write was dropped
// ============================================================================
module dl_ram_writer
    import dl_ram_writer_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
    parameter int AW         = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    input  logic          downloading,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic          cpu_ack,
    output logic [7:0]    cpu_dout,
    output logic          ram_req,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    input  logic          ram_ack,
    input  logic [7:0]    ram_dout,
    output logic          dl_busy,
    output logic          dl_overflow
);

    localparam int FW = AW + 8;

    // ------------------------------------------------------------------
    // Download write queue
    // ------------------------------------------------------------------
    logic [FW-1:0] fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_drop;
    logic          fifo_pop;

    dl_fifo #(
        .WIDTH      (FW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (dl_wr),
        .wdata ({dl_addr, dl_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    // ------------------------------------------------------------------
    // FSM / arbiter state
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic          ram_req_q, ram_req_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]    ram_din_q, ram_din_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic [7:0]    cpu_dout_q, cpu_dout_d;
    logic          dl_overflow_q, dl_overflow_d;
    // Set when a CPU access completes, cleared when a queued write starts:
    // guarantees one queued write between consecutive CPU accesses.
    logic          served_cpu_q, served_cpu_d;

    logic          cpu_req_eff;
    logic          dl_turn;

    always_comb begin
        // The CPU still shows cpu_req in the cycle cpu_ack is visible;
        // that level belongs to the access just finished, not a new one.
        cpu_req_eff = cpu_req && !cpu_ack_q;
        dl_turn     = !fifo_empty && (downloading || !cpu_req_eff || served_cpu_q);
        fifo_pop    = (state_q == ST_DL_WR) && ram_ack;

        state_d       = state_q;
        ram_req_d     = ram_req_q;
        ram_we_d      = ram_we_q;
        ram_addr_d    = ram_addr_q;
        ram_din_d     = ram_din_q;
        cpu_ack_d     = 1'b0;
        cpu_dout_d    = cpu_dout_q;
        served_cpu_d  = served_cpu_q;
        dl_overflow_d = dl_overflow_q || fifo_drop;

        case (state_q)
            ST_IDLE: begin
                if (dl_turn) begin
                    state_d      = ST_DL_WR;
                    ram_req_d    = 1'b1;
                    ram_we_d     = 1'b1;
                    ram_addr_d   = fifo_rdata[FW-1:8];
                    ram_din_d    = fifo_rdata[7:0];
                    served_cpu_d = 1'b0;
                end else if (cpu_req_eff) begin
                    state_d    = ST_CPU_ACC;
                    ram_req_d  = 1'b1;
                    ram_we_d   = cpu_we;
                    ram_addr_d = cpu_addr;
                    ram_din_d  = cpu_din;
                end
            end
            ST_DL_WR: begin
                // The head entry stays in the FIFO until acknowledged.
                if (ram_ack) begin
                    state_d   = ST_IDLE;
                    ram_req_d = 1'b0;
                end
            end
            ST_CPU_ACC: begin
                // Completes even if the CPU has withdrawn its request.
                if (ram_ack) begin
                    state_d      = ST_IDLE;
                    ram_req_d    = 1'b0;
                    cpu_ack_d    = 1'b1;
                    served_cpu_d = 1'b1;
                    if (!ram_we_q) begin
                        cpu_dout_d = ram_dout;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                ram_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ram_req_q     <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_din_q     <= 8'h00;
            cpu_ack_q     <= 1'b0;
            cpu_dout_q    <= 8'h00;
            served_cpu_q  <= 1'b0;
            dl_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ram_req_q     <= ram_req_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_din_q     <= ram_din_d;
            cpu_ack_q     <= cpu_ack_d;
            cpu_dout_q    <= cpu_dout_d;
            served_cpu_q  <= served_cpu_d;
            dl_overflow_q <= dl_overflow_d;
        end
    end

    assign ram_req     = ram_req_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;
    assign cpu_ack     = cpu_ack_q;
    assign cpu_dout    = cpu_dout_q;
    assign dl_overflow = dl_overflow_q;
    assign dl_busy     = !fifo_empty || (state_q == ST_DL_WR);

    // fifo_full is only needed inside the FIFO for push acceptance.
    logic unused_ok;
    assign unused_ok = fifo_full;

endmodule : dl_ram_writer
`default_nettype wire

// File: tb/tb_dl_ram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dl_ram_writer
//  Description : Self-checking bench for dl_ram_writer. Expected SDRAM
//                transactions are queued when stimulus is driven; a modelled
//                SDRAM controller pops and compares them as requests appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dl_ram_writer;

    localparam int AW = 25;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } txn_t;

    logic          clk;
    logic          reset;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          downloading;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_ack;
    logic [7:0]    cpu_dout;
    logic          ram_req;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_ack;
    logic [7:0]    ram_dout;
    logic          dl_busy;
    logic          dl_overflow;

    int   errors = 0;
    int   checks = 0;
    txn_t sb[$];

    // SDRAM model controls/state
    logic ack_hold  = 1'b0;
    int   ack_delay = 1;
    logic in_req    = 1'b0;
    logic prev_req  = 1'b0;
    int   wait_cnt  = 0;
    int   req_count = 0;
    txn_t cur;

    dl_ram_writer #(.DEPTH_LOG2(2), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .downloading (downloading),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_ack     (cpu_ack),
        .cpu_dout    (cpu_dout),
        .ram_req     (ram_req),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_ack     (ram_ack),
        .ram_dout    (ram_dout),
        .dl_busy     (dl_busy),
        .dl_overflow (dl_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SDRAM controller model + scoreboard consumer.
    initial begin : responder
        ram_ack  = 1'b0;
        ram_dout = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                in_req  = 1'b0;
                ram_ack = 1'b0;
            end else if (ram_ack) begin
                ram_ack = 1'b0;
            end else begin
                if (ram_req && !in_req) begin
                    checks++;
                    if (prev_req !== 1'b0) begin
                        errors++;
                        $display("FAIL req_gap: ram_req=%b in cycle before new request, required 0", prev_req);
                    end
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_req: we=%b addr=%h din=%h, no request expected",
                                 ram_we, ram_addr, ram_din);
                        cur = '{we: ram_we, addr: ram_addr, data: 8'h00};
                    end else begin
                        cur = sb.pop_front();
                        if (cur.we) begin
                            if ({ram_we, ram_addr, ram_din} !== {cur.we, cur.addr, cur.data}) begin
                                errors++;
                                $display("FAIL ram_txn: got we=%b addr=%h din=%h, required we=%b addr=%h din=%h",
                                         ram_we, ram_addr, ram_din, cur.we, cur.addr, cur.data);
                            end
                        end else if ({ram_we, ram_addr} !== {cur.we, cur.addr}) begin
                            errors++;
                            $display("FAIL ram_txn: got we=%b addr=%h, required read addr=%h",
                                     ram_we, ram_addr, cur.addr);
                        end
                    end
                    in_req   = 1'b1;
                    wait_cnt = 0;
                    req_count++;
                end
                if (in_req && !ack_hold) begin
                    wait_cnt++;
                    if (wait_cnt > ack_delay) begin
                        ram_ack  = 1'b1;
                        ram_dout = cur.we ? 8'h00 : cur.data;
                        in_req   = 1'b0;
                    end
                end
            end
            prev_req = ram_req;
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((sb.size() != 0 || dl_busy || ram_req || in_req || ram_ack) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_drain: timeout, pending=%0d busy=%b req=%b, required 0/0/0", tag, sb.size(), dl_busy, ram_req);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({ram_req, ram_we, ram_addr, ram_din, cpu_ack, cpu_dout, dl_busy, dl_overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h din=%h ack=%b dout=%h busy=%b ovf=%b, required all 0",
                     ram_req, ram_we, ram_addr, ram_din, cpu_ack, cpu_dout, dl_busy, dl_overflow);
        end
    endtask

    task automatic test_single();
        int n = 0;
        ack_delay = 3;
        @(posedge clk); #1;
        dl_wr = 1'b1; dl_addr = 25'h180000; dl_data = 8'hF3;
        sb.push_back('{we: 1'b1, addr: 25'h180000, data: 8'hF3});
        @(posedge clk); #1;
        dl_wr = 1'b0;
        checks++;
        if (ram_req !== 1'b0 || dl_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_push: req=%b busy=%b, required 0/1", ram_req, dl_busy);
        end
        @(posedge clk); #1;
        checks++;
        if (ram_req !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: ram_req=%b two cycles after dl_wr, required 1", ram_req);
        end
        while (n < 20) begin
            @(posedge clk); #3;
            if (ram_ack) break;
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL single_ack: no ram_ack seen, required one");
        end
        @(posedge clk); #1;
        checks++;
        if (dl_busy !== 1'b0 || ram_req !== 1'b0) begin
            errors++;
            $display("FAIL single_done: busy=%b req=%b after ack, required 0/0", dl_busy, ram_req);
        end
        wait_idle("single");
    endtask

    task automatic test_burst();
        int start_cnt;
        ack_hold  = 1'b1;
        ack_delay = 1;
        start_cnt = req_count;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 4) begin
                checks++;
                if (dl_overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_no_early_ovf: dl_overflow=%b with 4 queued, required 0", dl_overflow);
                end
            end
            dl_wr   = 1'b1;
            dl_addr = 25'h010000 + 25'(i);
            dl_data = 8'h10 + 8'(i);
            if (i < 4) sb.push_back('{we: 1'b1, addr: 25'h010000 + 25'(i), data: 8'h10 + 8'(i)});
        end
        @(posedge clk); #1;
        dl_wr = 1'b0;
        checks++;
        if (dl_overflow !== 1'b1 || dl_busy !== 1'b1) begin
            errors++;
            $display("FAIL burst_overflow: ovf=%b busy=%b, required 1/1", dl_overflow, dl_busy);
        end
        ack_hold = 1'b0;
        wait_idle("burst");
        checks++;
        if (req_count - start_cnt !== 4) begin
            errors++;
            $display("FAIL burst_count: %0d writes, required 4", req_count - start_cnt);
        end
        checks++;
        if (dl_overflow !== 1'b1) begin
            errors++;
            $display("FAIL burst_sticky: dl_overflow=%b, required 1", dl_overflow);
        end
    endtask

    task automatic test_full_pop();
        int start_cnt;
        ack_hold  = 1'b1;
        ack_delay = 0;
        start_cnt = req_count;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            dl_wr   = 1'b1;
            dl_addr = 25'h002000 + 25'(i);
            dl_data = 8'hA0 + 8'(i);
            sb.push_back('{we: 1'b1, addr: 25'h002000 + 25'(i), data: 8'hA0 + 8'(i)});
        end
        @(posedge clk); #1;
        dl_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Release the ack this cycle and push into the full FIFO together.
        ack_hold = 1'b0;
        dl_wr    = 1'b1;
        dl_addr  = 25'h002004;
        dl_data  = 8'hA4;
        sb.push_back('{we: 1'b1, addr: 25'h002004, data: 8'hA4});
        #2;
        checks++;
        if (ram_ack !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_align: ram_ack=%b during full push, required 1", ram_ack);
        end
        @(posedge clk); #1;
        dl_wr     = 1'b0;
        ack_delay = 1;
        checks++;
        if (dl_overflow !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_overflow: dl_overflow=%b, required 0", dl_overflow);
        end
        wait_idle("fullpop");
        checks++;
        if (req_count - start_cnt !== 5) begin
            errors++;
            $display("FAIL fullpop_count: %0d writes, required 5", req_count - start_cnt);
        end
    endtask

    task automatic test_arbitration();
        int n = 0;
        ack_hold    = 1'b1;
        ack_delay   = 2;
        downloading = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            dl_wr   = 1'b1;
            dl_addr = 25'h003000 + 25'(i);
            dl_data = 8'hC5 + 8'(i);
            sb.push_back('{we: 1'b1, addr: 25'h003000 + 25'(i), data: 8'hC5 + 8'(i)});
        end
        @(posedge clk); #1;
        dl_wr    = 1'b0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 25'h000100;
        cpu_din  = 8'h00;
        sb.push_back('{we: 1'b0, addr: 25'h000100, data: 8'h3E});
        repeat (2) @(posedge clk);
        #1;
        ack_hold = 1'b0;
        while (n < 100 && cpu_ack !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (cpu_ack !== 1'b1) begin
            errors++;
            $display("FAIL arb_cpu_ack: no cpu_ack seen, required one");
        end
        checks++;
        if (cpu_dout !== 8'h3E) begin
            errors++;
            $display("FAIL arb_cpu_dout: cpu_dout=%h, required 3e", cpu_dout);
        end
        cpu_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cpu_ack !== 1'b0 || cpu_dout !== 8'h3E) begin
            errors++;
            $display("FAIL arb_ack_pulse: ack=%b dout=%h, required 0/3e", cpu_ack, cpu_dout);
        end
        downloading = 1'b0;
        wait_idle("arb");
    endtask

    task automatic test_alternate();
        int acks = 0;
        int n    = 0;
        ack_hold    = 1'b1;
        ack_delay   = 1;
        downloading = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{we: 1'b1, addr: 25'h000200, data: 8'h5A});
            sb.push_back('{we: 1'b1, addr: 25'h004000 + 25'(i), data: 8'h60 + 8'(i)});
        end
        sb.push_back('{we: 1'b1, addr: 25'h000200, data: 8'h5A});
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 25'h000200;
        cpu_din  = 8'h5A;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            dl_wr   = 1'b1;
            dl_addr = 25'h004000 + 25'(i);
            dl_data = 8'h60 + 8'(i);
            @(posedge clk); #1;
        end
        dl_wr    = 1'b0;
        ack_hold = 1'b0;
        while (acks < 4 && n < 300) begin
            @(posedge clk); #1;
            if (cpu_ack === 1'b1) begin
                acks++;
                if (acks == 4) cpu_req = 1'b0;
            end
            n++;
        end
        checks++;
        if (acks !== 4) begin
            errors++;
            $display("FAIL alt_cpu_acks: %0d cpu_ack pulses, required 4", acks);
        end
        wait_idle("alt");
    endtask

    task automatic test_reset_mid();
        logic stray = 1'b0;
        ack_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            dl_wr   = 1'b1;
            dl_addr = 25'h005000 + 25'(i);
            dl_data = 8'h70 + 8'(i);
            if (i < 4) sb.push_back('{we: 1'b1, addr: 25'h005000 + 25'(i), data: 8'h70 + 8'(i)});
        end
        @(posedge clk); #1;
        dl_wr = 1'b0;
        checks++;
        if (ram_req !== 1'b1 || dl_overflow !== 1'b1 || cpu_dout !== 8'h3E) begin
            errors++;
            $display("FAIL rstmid_pre: req=%b ovf=%b dout=%h, required 1/1/3e", ram_req, dl_overflow, cpu_dout);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (ram_req !== 1'b0 || dl_busy !== 1'b0 || dl_overflow !== 1'b0 || cpu_dout !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_async: req=%b busy=%b ovf=%b dout=%h, required 0/0/0/00",
                     ram_req, dl_busy, dl_overflow, cpu_dout);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        ack_hold = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ram_req !== 1'b0 || dl_busy !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_discard: activity after reset (req=%b busy=%b), required none", ram_req, dl_busy);
        end
    endtask

    initial begin : main
        reset       = 1'b1;
        dl_wr       = 1'b0;
        dl_addr     = '0;
        dl_data     = 8'h00;
        downloading = 1'b0;
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
        cpu_addr    = '0;
        cpu_din     = 8'h00;
        @(posedge clk); #1;
        test_reset();
        apply_reset();
        test_single();
        test_burst();
        apply_reset();
        test_full_pop();
        test_arbitration();
        test_alternate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dl_ram_writer
`default_nettype wire
